toy_mem_req_bridge: RTL and testbench

TOY_MEM_REQ_BRIDGE -- requirements
Module: toy_mem_req_bridge

---
 rtl/toy_mem_req_bridge.sv | 98 +++++++++
 tb/tb_toy_mem_req_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_mem_req_bridge.sv
// Valid/ready request front-end for a 1-cycle-latency SRAM. Read data and write
// acknowledgements return in request order through a small response FIFO.
module toy_mem_req_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_wr_en,
  input  logic [DATA_WIDTH-1:0]   req_wr_data,
  input  logic [DATA_WIDTH/8-1:0] req_wr_byte_en,
  output logic                    ack_vld,
  input  logic                    ack_rdy,
  output logic [DATA_WIDTH-1:0]   ack_rd_data,
  output logic                    mem_en,
  output logic                    mem_wr_en,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] mem_wr_byte_en,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;

  logic                  p1_vld;
  logic                  p1_wr;
  logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  logic                  push;
  logic                  pop;
  logic                  unused_addr_bits;

  // The in-flight access already owns a FIFO slot, so it counts toward occupancy.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, p1_vld};
  assign req_rdy   = rst_n && (occupancy < (CW+1)'(RESP_DEPTH));

  assign mem_en         = req_vld && req_rdy;
  assign mem_wr_en      = mem_en && req_wr_en;
  assign mem_addr       = req_addr[MEM_AW+1:2];
  assign mem_wr_data    = req_wr_data;
  assign mem_wr_byte_en = req_wr_byte_en;

  assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:MEM_AW+2], req_addr[1:0]};

  assign push        = p1_vld;
  assign ack_vld     = (fifo_count != '0);
  assign pop         = ack_vld && ack_rdy;
  assign ack_rd_data = ack_vld ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_vld <= 1'b0;
      p1_wr  <= 1'b0;
    end else begin
      p1_vld <= mem_en;
      if (mem_en) begin
        p1_wr <= req_wr_en;
      end
    end
  end

  // Storage needs no reset: fifo_count gates every observable read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= p1_wr ? '0 : mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_toy_mem_req_bridge.sv
// Bench for toy_mem_req_bridge: SRAM model, in-order response queue model,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_toy_mem_req_bridge;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic        req_wr_en;
  logic [31:0] req_wr_data;
  logic [3:0]  req_wr_byte_en;
  logic        ack_vld;
  logic        ack_rdy;
  logic [31:0] ack_rd_data;
  logic        mem_en;
  logic        mem_wr_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_byte_en;
  logic [31:0] sram_rd;

  toy_mem_req_bridge #(
    .ADDR_WIDTH(32), .MEM_AW(10), .DATA_WIDTH(32), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_wr_en(req_wr_en), .req_wr_data(req_wr_data), .req_wr_byte_en(req_wr_byte_en),
    .ack_vld(ack_vld), .ack_rdy(ack_rdy), .ack_rd_data(ack_rd_data),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_byte_en(mem_wr_byte_en),
    .mem_rd_data(sram_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] wordInit(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  // SRAM seen by the DUT: one access per cycle, read data one cycle later.
  logic [31:0] sram [1024];
  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = wordInit(i);
    sram_rd = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_wr_en) begin
          for (int b = 0; b < 4; b++)
            if (mem_wr_byte_en[b]) sram[mem_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
        end else begin
          sram_rd <= sram[mem_addr];
        end
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    int          edge_n;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] popLog[$];
  logic [31:0] modelMem [1024];
  int          total = 0;
  int          bad = 0;
  logic        lastAccept;
  logic        lastRdy;
  logic        lastAckVld;
  logic [9:0]  lastMemAddr;
  int          memEnCount;
  int          accCount;

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Called just after a falling edge once inputs are set: compares, updates model, waits a cycle.
  task automatic checkOutput();
    logic        expRdy;
    logic        expVld;
    logic        expEn;
    int          idx;
    exp_t        e;
    #1;
    lastAccept = req_vld && req_rdy;
    lastRdy    = req_rdy;
    lastAckVld = ack_vld;
    if (mem_en === 1'b1) begin
      memEnCount++;
      lastMemAddr = mem_addr;
    end
    if (!rst_n) begin
      checkValue("rst_req_rdy", 64'(req_rdy), 64'd0);
      checkValue("rst_ack_vld", 64'(ack_vld), 64'd0);
      checkValue("rst_ack_data", 64'(ack_rd_data), 64'd0);
      checkValue("rst_mem_en", 64'(mem_en), 64'd0);
      checkValue("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
      expQ.delete();
    end else begin
      expRdy = (expQ.size() < DEPTH);
      expVld = (expQ.size() > 0) && (expQ[0].edge_n + 1 <= cyc);
      expEn  = req_vld && expRdy;
      checkValue("req_rdy", 64'(req_rdy), 64'(expRdy));
      checkValue("ack_vld", 64'(ack_vld), 64'(expVld));
      if (expVld) checkValue("ack_rd_data", 64'(ack_rd_data), 64'(expQ[0].data));
      checkValue("mem_en", 64'(mem_en), 64'(expEn));
      checkValue("mem_wr_en", 64'(mem_wr_en), 64'(expEn && req_wr_en));
      idx = int'((req_addr >> 2) & 32'd1023);
      if (expEn) begin
        checkValue("mem_addr", 64'(mem_addr), 64'(idx));
        checkValue("mem_wr_data", 64'(mem_wr_data), 64'(req_wr_data));
        checkValue("mem_wr_byte_en", 64'(mem_wr_byte_en), 64'(req_wr_byte_en));
      end
      if (expVld && ack_rdy) begin
        popLog.push_back(expQ[0].data);
        void'(expQ.pop_front());
      end
      if (expEn) begin
        e.edge_n = cyc + 1;
        if (req_wr_en) begin
          e.data = '0;
          for (int b = 0; b < 4; b++)
            if (req_wr_byte_en[b]) modelMem[idx][8*b +: 8] = req_wr_data[8*b +: 8];
        end else begin
          e.data = modelMem[idx];
        end
        expQ.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rstN, input logic vld, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be, input logic ackRdy);
    rst_n          = rstN;
    req_vld        = vld;
    req_wr_en      = wr;
    req_addr       = addr;
    req_wr_data    = data;
    req_wr_byte_en = be;
    ack_rdy        = ackRdy;
    checkOutput();
  endtask

  task automatic idle(input int n, input logic ackRdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ackRdy);
  endtask

  initial begin
    rst_n = 1'b0; req_vld = 1'b0; req_wr_en = 1'b0; req_addr = '0;
    req_wr_data = '0; req_wr_byte_en = '0; ack_rdy = 1'b0;
    memEnCount = 0;
    for (int i = 0; i < 1024; i++) modelMem[i] = wordInit(i);
    @(negedge clk);

    // Reset holds everything quiet even with a request pending.
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    checkValue("rdy_after_release", 64'(lastRdy), 64'd1);

    // Write then read the same word.
    popLog.delete(); memEnCount = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1);
    idle(4, 1'b1);
    checkValue("wr_rd_mem_en_pulses", 64'(memEnCount), 64'd2);
    checkValue("wr_rd_ack_count", 64'(popLog.size()), 64'd2);
    if (popLog.size() >= 2) begin
      checkValue("wr_ack_zero", 64'(popLog[0]), 64'h0);
      checkValue("rd_ack_deadbeef", 64'(popLog[1]), 64'hDEAD_BEEF);
    end

    // Partial byte-lane write over all-ones.
    popLog.delete();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'h5, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    idle(4, 1'b1);
    checkValue("be_ack_count", 64'(popLog.size()), 64'd3);
    if (popLog.size() >= 3) checkValue("be_merge", 64'(popLog[2]), 64'hFF22_FF44);

    // Address bits above the word index and below the word are dropped.
    popLog.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h1003, 32'h0, 4'h0, 1'b1);
    checkValue("alias_mem_addr", 64'(lastMemAddr), 64'h0);
    idle(4, 1'b1);
    checkValue("alias_ack_count", 64'(popLog.size()), 64'd1);
    if (popLog.size() >= 1) checkValue("alias_ack_data", 64'(popLog[0]), 64'hDEAD_BEEF);

    // Backpressure fills the response path, then drains in order.
    popLog.delete(); accCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4*i), 32'h0, 4'h0, 1'b0);
      if (lastAccept) accCount++;
    end
    checkValue("full_accepts", 64'(accCount), 64'd4);
    checkValue("full_rdy_low", 64'(lastRdy), 64'd0);
    idle(1, 1'b1);
    idle(1, 1'b1);
    checkValue("rdy_after_pop", 64'(lastRdy), 64'd1);
    idle(6, 1'b1);
    checkValue("drain_count", 64'(popLog.size()), 64'd4);
    for (int k = 0; k < 4 && k < popLog.size(); k++)
      checkValue("drain_order", 64'(popLog[k]), 64'(wordInit(16'h40 + k)));

    // Sixteen back-to-back reads with the ack side always ready.
    popLog.delete();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'(4*i), 32'h0, 4'h0, 1'b1);
      checkValue("b2b_accept", 64'(lastAccept), 64'd1);
    end
    idle(4, 1'b1);
    checkValue("b2b_ack_count", 64'(popLog.size()), 64'd16);
    for (int k = 0; k < 16 && k < popLog.size(); k++)
      checkValue("b2b_order", 64'(popLog[k]), 64'(modelMem[k]));

    // Reset with one access in flight and two responses buffered.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'(8*i), 32'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    checkValue("midrst_ack_vld", 64'(lastAckVld), 64'd0);
    checkValue("midrst_rdy", 64'(lastRdy), 64'd0);
    popLog.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    checkValue("midrst_rdy_release", 64'(lastRdy), 64'd1);
    idle(5, 1'b1);
    checkValue("midrst_no_stale", 64'(popLog.size()), 64'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(logic'($urandom_range(0, 299) != 0), logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 1)),
                    ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2),
                    $urandom, 4'($urandom), logic'($urandom_range(0, 3) != 0));
    end
    idle(8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
